rr_resource_arbiter: RTL and testbench

- Round-robin arbiter that shares one datapath resource (e.g. the neuron MAC unit) between N requesters.
- Rotating one-hot priority pointer gives fair access; hold-limit timer stops any requester monopolising the resource.
- Sits between the per-neuron/per-layer sequencers and the shared resource; the grant vector drives the resource's input mux select.

---
 rtl/rr_arb_pkg.sv | 34 +++
 rtl/rr_pick.sv | 29 ++
 rtl/rr_resource_arbiter.sv | 123 ++++++++++++
 tb/tb_rr_resource_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb_pkg
//  Purpose  : Shared constants and helpers for the round-robin resource arbiter
//  Revision : 1.0  initial release
// ============================================================================
package rr_arb_pkg;

    // Helpers work on a fixed maximum width; callers zero-extend/truncate.
    localparam int c_MAX_N     = 32;
    localparam int c_MAX_IDX_W = 5;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_GRANT = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    function automatic logic [c_MAX_IDX_W-1:0] onehot_to_idx(input logic [c_MAX_N-1:0] v);
        logic [c_MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < c_MAX_N; i++) begin
            if (v[i]) idx = idx | i[c_MAX_IDX_W-1:0];
        end
        return idx;
    endfunction

    // Rotate an n-bit one-hot value left by one position, wrapping bit n-1 to bit 0.
    function automatic logic [c_MAX_N-1:0] rotl1(input logic [c_MAX_N-1:0] v, input int n);
        logic [c_MAX_N-1:0] mask;
        mask = {c_MAX_N{1'b1}} >> (c_MAX_N - n);
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin winner select (double-width masked PE)
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_prio_ptr,
    output logic [N-1:0] o_winner,
    output logic         o_any_req
);

    logic [N-1:0]   w_mask;
    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_lowest;

    // Low half holds requests at or above the pointer; the high half holds all
    // requests, so the lowest set bit of the whole word is the wrapped winner.
    assign w_mask    = ~(i_prio_ptr - N'(1));
    assign w_dbl     = {i_req, i_req & w_mask};
    assign w_lowest  = w_dbl & (~w_dbl + (2*N)'(1));
    assign o_winner  = w_lowest[N-1:0] | w_lowest[2*N-1:N];
    assign o_any_req = |i_req;

endmodule
`default_nettype wire

// File: rtl/rr_resource_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_resource_arbiter
//  Purpose  : Round-robin arbiter with hold limit sharing one resource among N
//             requesters (N up to 32). release_txn is the transaction-complete
//             strobe ("release" is a reserved word).
//  Revision : 1.0  initial release
// ============================================================================
module rr_resource_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             release_txn,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout,
    output logic [N-1:0]     prio_ptr
);

    localparam int c_HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    logic [1:0]          r_state,       w_state_nxt;
    logic [N-1:0]        r_grant,       w_grant_nxt;
    logic                r_grant_valid, w_valid_nxt;
    logic [IDX_W-1:0]    r_grant_idx,   w_idx_nxt;
    logic [N-1:0]        r_prio_ptr,    w_ptr_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt,    w_hold_nxt;
    logic                w_timeout;

    logic [N-1:0] w_winner;
    logic         w_any_req;
    logic         w_owner_req;
    logic         w_hold_hit;
    logic         w_exit;

    rr_pick #(.N(N)) u_pick (
        .i_req      (req),
        .i_prio_ptr (r_prio_ptr),
        .o_winner   (w_winner),
        .o_any_req  (w_any_req)
    );

    assign w_owner_req = |(req & r_grant);
    assign w_hold_hit  = (MAX_HOLD != 0) && (r_hold_cnt == c_HOLD_W'(MAX_HOLD));
    assign w_exit      = release_txn | ~w_owner_req | w_hold_hit;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_grant_idx;
        w_ptr_nxt   = r_prio_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_timeout   = 1'b0;
        case (r_state)
            // The gap cycle is the single dead slot between owners; the next
            // owner is chosen at its closing edge, exactly as from idle.
            c_ST_IDLE, c_ST_GAP: begin
                w_state_nxt = c_ST_IDLE;
                w_grant_nxt = '0;
                w_idx_nxt   = '0;
                w_hold_nxt  = '0;
                if (w_any_req) begin
                    w_state_nxt = c_ST_GRANT;
                    w_grant_nxt = w_winner;
                    w_idx_nxt   = IDX_W'(onehot_to_idx(c_MAX_N'(w_winner)));
                    w_ptr_nxt   = N'(rotl1(c_MAX_N'(w_winner), N));
                    w_hold_nxt  = c_HOLD_W'(1);
                end
            end
            c_ST_GRANT: begin
                if (w_exit) begin
                    w_state_nxt = c_ST_GAP;
                    w_grant_nxt = '0;
                    w_idx_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_timeout   = w_hold_hit & ~release_txn & w_owner_req & ~reset;
                end else if (MAX_HOLD != 0) begin
                    w_hold_nxt  = r_hold_cnt + c_HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_grant_nxt = '0;
                w_idx_nxt   = '0;
                w_hold_nxt  = '0;
            end
        endcase
        w_valid_nxt = |w_grant_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_prio_ptr    <= N'(1);
            r_hold_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= w_valid_nxt;
            r_grant_idx   <= w_idx_nxt;
            r_prio_ptr    <= w_ptr_nxt;
            r_hold_cnt    <= w_hold_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;
    assign prio_ptr    = r_prio_ptr;
    assign timeout     = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_resource_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_resource_arbiter
//  Purpose  : Self-checking bench for rr_resource_arbiter (N=4, MAX_HOLD=8)
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_resource_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic         release_txn;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_idx;
    logic         timeout;
    logic [N-1:0] prio_ptr;

    rr_resource_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .release_txn (release_txn),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout),
        .prio_ptr    (prio_ptr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_pass;

    // Reference model: current owner index (-1 when none), granted-cycle count,
    // and priority pointer as a plain index.
    int m_owner;
    int m_cnt;
    int m_ptr;

    logic [N-1:0] exp_grant;
    logic         exp_valid;
    logic [1:0]   exp_idx;
    logic [N-1:0] exp_ptr;
    logic         exp_to;
    logic         obs_to;
    logic [N-1:0] obs_pre_grant;

    // Drive one cycle: sample pre-edge outputs, clock, advance the model.
    task automatic step(input logic rst_v, input logic [N-1:0] rq, input logic rl);
        int w;
        reset       = rst_v;
        req         = rq;
        release_txn = rl;
        #1;
        obs_to        = timeout;
        obs_pre_grant = grant;
        exp_to        = 1'b0;
        if (!rst_v && m_owner >= 0)
            exp_to = (m_cnt == MAX_HOLD) && !rl && rq[m_owner];
        @(posedge clk);
        if (rst_v) begin
            m_owner = -1; m_cnt = 0; m_ptr = 0;
        end else if (m_owner < 0) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
                m_owner = w; m_cnt = 1; m_ptr = (w + 1) % N;
            end
        end else if (rl || !rq[m_owner] || m_cnt == MAX_HOLD) begin
            m_owner = -1; m_cnt = 0;
        end else begin
            m_cnt++;
        end
        exp_grant = (m_owner < 0) ? '0 : (4'b0001 << m_owner);
        exp_valid = (m_owner >= 0);
        exp_idx   = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        exp_ptr   = 4'b0001 << m_ptr;
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b1111, 1'b1);
        n_checks++;
        if ({grant, grant_valid, grant_idx} !== 7'b0000_0_00) begin
            $display("FAIL reset_grant got grant=%b v=%b idx=%0d, expected 0000 0 0", grant, grant_valid, grant_idx);
        end else n_pass++;
        n_checks++;
        if (prio_ptr !== 4'b0001) begin
            $display("FAIL reset_ptr got %b, expected 0001", prio_ptr);
        end else n_pass++;
        n_checks++;
        if (obs_to !== 1'b0) begin
            $display("FAIL reset_timeout got %b, expected 0", obs_to);
        end else n_pass++;
    endtask

    task automatic test_single;
        step(1'b0, 4'b0001, 1'b0);
        n_checks++;
        if ({grant, grant_valid, grant_idx} !== 7'b0001_1_00) begin
            $display("FAIL single_grant got grant=%b v=%b idx=%0d, expected 0001 1 0", grant, grant_valid, grant_idx);
        end else n_pass++;
        n_checks++;
        if (prio_ptr !== 4'b0010) begin
            $display("FAIL single_ptr got %b, expected 0010", prio_ptr);
        end else n_pass++;
        step(1'b0, 4'b0000, 1'b0);
        n_checks++;
        if ({grant, grant_valid} !== 5'b0000_0) begin
            $display("FAIL single_drop got grant=%b v=%b, expected 0000 0", grant, grant_valid);
        end else n_pass++;
        step(1'b0, 4'b0000, 1'b0);
    endtask

    task automatic test_rotation;
        logic [N-1:0] lit;
        step(1'b1, 4'b0000, 1'b0);
        for (int s = 1; s <= 14; s++) begin
            step(1'b0, 4'b1111, (m_owner >= 0 && m_cnt == 2));
            lit = ((s - 1) % 3 == 2) ? 4'b0000 : 4'(1 << (((s - 1) / 3) % 4));
            n_checks++;
            if (grant !== lit) begin
                $display("FAIL rotation_seq step=%0d got %b, expected %b", s, grant, lit);
            end else n_pass++;
            n_checks++;
            if ({grant, grant_valid, grant_idx, prio_ptr} !== {exp_grant, exp_valid, exp_idx, exp_ptr}) begin
                $display("FAIL rotation_model step=%0d got %b/%b/%0d/%b, expected %b/%b/%0d/%b",
                         s, grant, grant_valid, grant_idx, prio_ptr, exp_grant, exp_valid, exp_idx, exp_ptr);
            end else n_pass++;
        end
    endtask

    task automatic test_hold_limit;
        logic [N-1:0] lit;
        int p;
        step(1'b1, 4'b0000, 1'b0);
        for (int s = 1; s <= 19; s++) begin
            step(1'b0, 4'b0101, 1'b0);
            p   = s - 1;
            lit = (p >= 1 && p <= 8) ? 4'b0001 : (p >= 10 && p <= 17) ? 4'b0100 : 4'b0000;
            n_checks++;
            if (obs_pre_grant !== lit || obs_to !== (p == 8 || p == 17)) begin
                $display("FAIL hold_limit cycle=%0d got grant=%b timeout=%b, expected grant=%b timeout=%b",
                         p, obs_pre_grant, obs_to, lit, (p == 8 || p == 17));
            end else n_pass++;
            n_checks++;
            if (grant !== exp_grant || obs_to !== exp_to) begin
                $display("FAIL hold_model step=%0d got grant=%b to=%b, expected grant=%b to=%b",
                         s, grant, obs_to, exp_grant, exp_to);
            end else n_pass++;
        end
    endtask

    task automatic test_simul_exit;
        step(1'b1, 4'b0000, 1'b0);
        for (int s = 1; s <= 10; s++) begin
            step(1'b0, 4'b0101, (s == 9));
            if (s == 9) begin
                n_checks++;
                if (obs_to !== 1'b0 || obs_pre_grant !== 4'b0001) begin
                    $display("FAIL simul_timeout got to=%b grant=%b, expected to=0 grant=0001", obs_to, obs_pre_grant);
                end else n_pass++;
                n_checks++;
                if (grant !== 4'b0000) begin
                    $display("FAIL simul_end got %b, expected 0000", grant);
                end else n_pass++;
            end
        end
        n_checks++;
        if (grant !== 4'b0100) begin
            $display("FAIL simul_next got %b, expected 0100", grant);
        end else n_pass++;
    endtask

    task automatic test_wrap_abandon;
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        n_checks++;
        if (prio_ptr !== 4'b1000 || grant !== 4'b0000) begin
            $display("FAIL wrap_ptr got ptr=%b grant=%b, expected 1000 0000", prio_ptr, grant);
        end else n_pass++;
        step(1'b0, 4'b0011, 1'b0);
        n_checks++;
        if (grant !== 4'b0001 || prio_ptr !== 4'b0010) begin
            $display("FAIL wrap_grant got grant=%b ptr=%b, expected 0001 0010", grant, prio_ptr);
        end else n_pass++;
        step(1'b0, 4'b0010, 1'b0);
        n_checks++;
        if (grant !== 4'b0000) begin
            $display("FAIL abandon_clear got %b, expected 0000", grant);
        end else n_pass++;
        step(1'b0, 4'b0010, 1'b0);
        n_checks++;
        if (grant !== 4'b0010 || grant_idx !== 2'd1) begin
            $display("FAIL abandon_next got grant=%b idx=%0d, expected 0010 1", grant, grant_idx);
        end else n_pass++;
    endtask

    task automatic test_reset_mid;
        step(1'b1, 4'b0000, 1'b0);
        for (int s = 1; s <= 8; s++) step(1'b0, 4'b0100, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        n_checks++;
        if (obs_pre_grant !== 4'b0100 || obs_to !== 1'b0) begin
            $display("FAIL rstmid_pre got grant=%b to=%b, expected 0100 0", obs_pre_grant, obs_to);
        end else n_pass++;
        n_checks++;
        if (grant !== 4'b0000 || prio_ptr !== 4'b0001 || grant_valid !== 1'b0) begin
            $display("FAIL rstmid_post got grant=%b ptr=%b v=%b, expected 0000 0001 0", grant, prio_ptr, grant_valid);
        end else n_pass++;
        step(1'b0, 4'b1010, 1'b0);
        n_checks++;
        if (grant !== 4'b0010) begin
            $display("FAIL rstmid_next got %b, expected 0010", grant);
        end else n_pass++;
    endtask

    task automatic test_random;
        logic [N-1:0] rq;
        logic         rl;
        logic         rs;
        step(1'b1, 4'b0000, 1'b0);
        rq = 4'b0000;
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            rl = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 63) == 0);
            step(rs, rq, rl);
            n_checks++;
            if ({grant, grant_valid, grant_idx, prio_ptr} !== {exp_grant, exp_valid, exp_idx, exp_ptr}
                || obs_to !== exp_to || !$onehot0(grant)) begin
                $display("FAIL random step=%0d got %b/%b/%0d/%b to=%b, expected %b/%b/%0d/%b to=%b",
                         s, grant, grant_valid, grant_idx, prio_ptr, obs_to,
                         exp_grant, exp_valid, exp_idx, exp_ptr, exp_to);
            end else n_pass++;
        end
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        m_owner     = -1;
        m_cnt       = 0;
        m_ptr       = 0;
        reset       = 1'b1;
        req         = '0;
        release_txn = 1'b0;
        test_reset;
        test_single;
        test_rotation;
        test_hold_limit;
        test_simul_exit;
        test_wrap_abandon;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
